indexed_vertex_fetch: RTL and testbench



---
 rtl/gpu_pkg.sv | 25 ++
 rtl/vertex_cache.sv | 48 ++++
 rtl/indexed_vertex_fetch.sv | 157 +++++++++++++++
 tb/tb_indexed_vertex_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared geometry-pipeline types and constants for the vertex fetch front end.
package gpu_pkg;

   localparam int unsigned MATERIAL_W        = 12;
   localparam int unsigned FETCH_MEM_LATENCY = 2;
   localparam int unsigned CACHE_SLOTS       = 4;

   typedef logic [2:0][31:0] vertex_t;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_IDX_REQ,
      FS_IDX_WAIT,
      FS_VTX_REQ,
      FS_VTX_WAIT,
      FS_EMIT,
      FS_DONE
   } fetch_state_t;

   // Index-buffer address of corner k of triangle t; 16-bit wrap is safe for legal list sizes.
   function automatic logic [15:0] idx_addr_f(input logic [15:0] tri_idx, input logic [1:0] corner);
      return 16'(tri_idx + tri_idx + tri_idx + 16'(corner));
   endfunction

endpackage

// File: rtl/vertex_cache.sv
// Direct-mapped vertex position cache: slot = index[1:0], tag = index[15:2].
module vertex_cache
   import gpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        invalidate,
   input  logic [15:0] lookup_index,
   output logic        hit_c,
   output logic [95:0] lookup_data_c,
   input  logic        fill,
   input  logic [15:0] fill_index,
   input  logic [95:0] fill_data
);

   localparam int unsigned SLOT_W = $clog2(CACHE_SLOTS);
   localparam int unsigned TAG_W  = 16 - SLOT_W;

   logic [CACHE_SLOTS-1:0] slot_valid;
   logic [TAG_W-1:0]       slot_tag  [CACHE_SLOTS];
   vertex_t                slot_data [CACHE_SLOTS];
   logic [SLOT_W-1:0]      lk_slot_c;
   logic [SLOT_W-1:0]      fl_slot_c;

   always_comb begin
      lk_slot_c     = lookup_index[SLOT_W-1:0];
      fl_slot_c     = fill_index[SLOT_W-1:0];
      hit_c         = slot_valid[lk_slot_c] && (slot_tag[lk_slot_c] == lookup_index[15:SLOT_W]);
      lookup_data_c = slot_data[lk_slot_c];
   end

   always_ff @(posedge clk) begin
      if (rst || invalidate) begin
         slot_valid <= '0;
      end else if (fill) begin
         slot_valid[fl_slot_c] <= 1'b1;
      end
   end

   // Payload storage needs no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (fill) begin
         slot_tag[fl_slot_c]  <= fill_index[15:SLOT_W];
         slot_data[fl_slot_c] <= fill_data;
      end
   end

endmodule

// File: rtl/indexed_vertex_fetch.sv
// Walks an indexed triangle list and streams one vertex per ready/valid beat.
// Define VERTEX_CACHE_EN to add the 4-entry vertex reuse cache.
module indexed_vertex_fetch
   import gpu_pkg::*;
#(
   parameter int unsigned TRI_COUNT = 12
)
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [15:0]           idx_addr_out,
   input  logic [15:0]           idx_data_in,
   output logic [15:0]           vtx_addr_out,
   input  logic [95:0]           vtx_data_in,
   output logic [15:0]           mat_addr_out,
   input  logic [MATERIAL_W-1:0] mat_data_in,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [15:0]           vertex_id_out,
   output logic [95:0]           vertex_out,
   output logic [MATERIAL_W-1:0] material_out,
   output logic                  last_out
);

   localparam int unsigned WAIT_W = (FETCH_MEM_LATENCY > 1) ? $clog2(FETCH_MEM_LATENCY) : 1;

   fetch_state_t      state;
   logic [15:0]       tri_idx;
   logic [1:0]        corner;
   logic [WAIT_W-1:0] wait_cnt;

   logic        wait_done_c;
   logic        final_c;
   logic        start_ok_c;
   logic        fill_c;
   logic [15:0] tri_nxt_c;
   logic [1:0]  corner_nxt_c;
   logic        cache_hit_c;
   logic [95:0] cache_data_c;

   always_comb begin
      wait_done_c  = (wait_cnt == WAIT_W'(FETCH_MEM_LATENCY - 1));
      final_c      = (tri_idx == 16'(TRI_COUNT - 1)) && (corner == 2'd2);
      start_ok_c   = start_in && ((state == FS_IDLE) || (state == FS_DONE));
      fill_c       = (state == FS_VTX_WAIT) && wait_done_c;
      tri_nxt_c    = (corner == 2'd2) ? 16'(tri_idx + 16'd1) : tri_idx;
      corner_nxt_c = (corner == 2'd2) ? 2'd0 : 2'(corner + 2'd1);
   end

`ifdef VERTEX_CACHE_EN
   vertex_cache u_cache (
      .clk           (clk_in),
      .rst           (rst_in),
      .invalidate    (start_ok_c),
      .lookup_index  (idx_data_in),
      .hit_c         (cache_hit_c),
      .lookup_data_c (cache_data_c),
      .fill          (fill_c),
      .fill_index    (vertex_id_out),
      .fill_data     (vtx_data_in)
   );
`else
   assign cache_hit_c  = 1'b0;
   assign cache_data_c = '0;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= FS_IDLE;
         tri_idx       <= '0;
         corner        <= '0;
         wait_cnt      <= '0;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
         idx_addr_out  <= '0;
         vtx_addr_out  <= '0;
         mat_addr_out  <= '0;
         valid_out     <= 1'b0;
         vertex_id_out <= '0;
         vertex_out    <= '0;
         material_out  <= '0;
         last_out      <= 1'b0;
      end else begin
         case (state)
            FS_IDLE, FS_DONE: begin
               if (start_ok_c) begin
                  state        <= FS_IDX_REQ;
                  tri_idx      <= '0;
                  corner       <= '0;
                  idx_addr_out <= '0;
                  mat_addr_out <= '0;
                  busy_out     <= 1'b1;
                  done_out     <= 1'b0;
               end
            end
            FS_IDX_REQ: begin
               state    <= FS_IDX_WAIT;
               wait_cnt <= '0;
            end
            FS_IDX_WAIT: begin
               if (wait_done_c) begin
                  vertex_id_out <= idx_data_in;
                  if (corner == 2'd0) material_out <= mat_data_in;
                  // A cache hit skips the vertex memory round trip entirely.
                  if (cache_hit_c) begin
                     vertex_out <= cache_data_c;
                     valid_out  <= 1'b1;
                     last_out   <= final_c;
                     state      <= FS_EMIT;
                  end else begin
                     vtx_addr_out <= idx_data_in;
                     state        <= FS_VTX_REQ;
                  end
               end else begin
                  wait_cnt <= WAIT_W'(wait_cnt + 1'b1);
               end
            end
            FS_VTX_REQ: begin
               state    <= FS_VTX_WAIT;
               wait_cnt <= '0;
            end
            FS_VTX_WAIT: begin
               if (wait_done_c) begin
                  vertex_out <= vtx_data_in;
                  valid_out  <= 1'b1;
                  last_out   <= final_c;
                  state      <= FS_EMIT;
               end else begin
                  wait_cnt <= WAIT_W'(wait_cnt + 1'b1);
               end
            end
            FS_EMIT: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  last_out  <= 1'b0;
                  if (final_c) begin
                     state    <= FS_DONE;
                     busy_out <= 1'b0;
                     done_out <= 1'b1;
                  end else begin
                     tri_idx      <= tri_nxt_c;
                     corner       <= corner_nxt_c;
                     idx_addr_out <= idx_addr_f(tri_nxt_c, corner_nxt_c);
                     if (corner_nxt_c == 2'd0) mat_addr_out <= tri_nxt_c;
                     state        <= FS_IDX_REQ;
                  end
               end
            end
            default: state <= FS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_indexed_vertex_fetch.sv
// Scoreboard bench: two fetch units (TRI_COUNT 1 and 2) share start/ready/reset,
// each with its own latency-2 memories, reference stream queue and monitor.
module tb_indexed_vertex_fetch;
   import gpu_pkg::*;

   localparam int NI = 2;
`ifdef VERTEX_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b1;
   logic start = 1'b0;
   logic ready = 1'b1;
   int   n_chk = 0, n_fail = 0, cyc = 0;
   int   ready_mode = 0, stall_n = 0;

   logic [15:0] idx_mem [0:7];
   logic [11:0] mat_mem [0:1];
   logic [31:0] seed;
   int          hs_cnt [NI];
   int          pend   [NI];

   logic        busy_o [NI], done_o [NI], valid_o [NI], last_o [NI];
   logic [15:0] ia_o [NI], va_o [NI], ma_o [NI], id_o [NI];
   logic [95:0] vtx_o [NI];
   logic [11:0] mat_o [NI];

   typedef struct {
      logic [15:0] id;
      logic [95:0] vtx;
      logic [11:0] mat;
      logic        last;
      int          lat;
      logic [15:0] ia, va, ma;
   } beat_t;

   // Vertex memory contents are a hash of the full address, so any address bit error shows.
   function automatic logic [95:0] vtx_f(input logic [15:0] a, input logic [31:0] s);
      logic [31:0] w;
      w = {16'h0, a};
      return {(w * 32'h9E3779B1) ^ s, {a, ~a} ^ {s[15:0], s[31:16]}, w + (s * 32'd3)};
   endfunction

   task automatic chk(input string nm, input int g, input logic [127:0] act, input logic [127:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, g, act, exp_v);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar g = 0; g < NI; g++) begin : gi
         localparam int unsigned TC = g + 1;
         logic [15:0] ia_d, va_d, ma_d, idx_q;
         logic [95:0] vtx_q;
         logic [11:0] mat_q;
         beat_t       q[$];
         int          last_ev = 0;
         bit          stalled = 0, exp_done = 0, rst_prev = 0;

         indexed_vertex_fetch #(.TRI_COUNT(TC)) dut (
            .clk_in(clk), .rst_in(rst), .start_in(start),
            .busy_out(busy_o[g]), .done_out(done_o[g]),
            .idx_addr_out(ia_o[g]), .idx_data_in(idx_q),
            .vtx_addr_out(va_o[g]), .vtx_data_in(vtx_q),
            .mat_addr_out(ma_o[g]), .mat_data_in(mat_q),
            .valid_out(valid_o[g]), .ready_in(ready),
            .vertex_id_out(id_o[g]), .vertex_out(vtx_o[g]),
            .material_out(mat_o[g]), .last_out(last_o[g])
         );

         // Two-stage synchronous-read memories.
         always @(posedge clk) begin
            ia_d  <= ia_o[g];
            va_d  <= va_o[g];
            ma_d  <= ma_o[g];
            idx_q <= (ia_d < 16'd8) ? idx_mem[ia_d[2:0]] : 16'hBAD0;
            vtx_q <= vtx_f(va_d, seed);
            mat_q <= (ma_d < 16'd2) ? mat_mem[ma_d[0]] : 12'hBAD;
         end

         always @(negedge clk) begin : mon
            beat_t       e;
            bit          cv [4];
            logic [15:0] ct [4];
            logic [15:0] a, id, lastv;
            bit          hit;
            int          slot;
            if (rst_prev) begin
               chk("reset_ctrl", g, 128'({busy_o[g], done_o[g], valid_o[g], last_o[g]}), 128'(0));
               chk("reset_addr", g, 128'({ia_o[g], va_o[g], ma_o[g]}), 128'(0));
               chk("reset_data", g, 128'({id_o[g], mat_o[g], vtx_o[g]}), 128'(0));
            end
            rst_prev = rst;
            if (rst) begin
               q.delete();
               stalled  = 0;
               exp_done = 0;
            end else begin
               if (exp_done) begin
                  chk("done_after_last", g, 128'({done_o[g], busy_o[g]}), 128'(2'b10));
                  exp_done = 0;
               end
               if (start && !busy_o[g]) begin
                  chk("lost_beats", g, 128'(q.size()), 128'(0));
                  q.delete();
                  for (int i = 0; i < 4; i++) begin cv[i] = 0; ct[i] = '0; end
                  lastv = '0;
                  for (int t = 0; t < int'(TC); t++) begin
                     for (int k = 0; k < 3; k++) begin
                        a    = 16'(3 * t + k);
                        id   = idx_mem[a[2:0]];
                        slot = int'(id % 16'd4);
                        hit  = CACHE_ON && cv[slot] && (ct[slot] == id);
                        if (!hit) begin cv[slot] = 1; ct[slot] = id; lastv = id; end
                        e.id   = id;
                        e.vtx  = vtx_f(id, seed);
                        e.mat  = mat_mem[t];
                        e.last = (t == int'(TC) - 1) && (k == 2);
                        e.lat  = hit ? 4 : 7;
                        e.ia   = a;
                        e.va   = lastv;
                        e.ma   = 16'(t);
                        q.push_back(e);
                     end
                  end
                  last_ev   = cyc;
                  hs_cnt[g] = 0;
                  stalled   = 0;
               end
               if (valid_o[g]) begin
                  chk("beat_expected", g, 128'(q.size() != 0), 128'(1));
                  if (q.size() != 0) begin
                     e = q[0];
                     if (!stalled) chk("latency", g, 128'(cyc - last_ev), 128'(e.lat));
                     chk("vertex_id", g, 128'(id_o[g]), 128'(e.id));
                     chk("vertex", g, 128'(vtx_o[g]), 128'(e.vtx));
                     chk("material", g, 128'(mat_o[g]), 128'(e.mat));
                     chk("last_busy", g, 128'({last_o[g], busy_o[g]}), 128'({e.last, 1'b1}));
                     chk("addr_hold", g, 128'({ia_o[g], va_o[g], ma_o[g]}), 128'({e.ia, e.va, e.ma}));
                     if (ready) begin
                        void'(q.pop_front());
                        last_ev = cyc;
                        hs_cnt[g]++;
                        if (e.last) exp_done = 1;
                        stalled = 0;
                     end else begin
                        stalled = 1;
                     end
                  end
               end
            end
            pend[g] = q.size();
         end
      end
   endgenerate

   // Downstream ready: always, random, five-cycle stall on beat 2, or held low.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (valid_o[1] && hs_cnt[1] == 1 && stall_n < 5) begin
               ready = 1'b0;
               stall_n++;
            end else begin
               ready = 1'b1;
            end
         end
         3: ready = 1'b0;
         default: ready = 1'b1;
      endcase
   end

   task automatic load_directed();
      idx_mem[0] = 16'd0; idx_mem[1] = 16'd1; idx_mem[2] = 16'd2;
      idx_mem[3] = 16'd2; idx_mem[4] = 16'd1; idx_mem[5] = 16'd3;
      idx_mem[6] = 16'd0; idx_mem[7] = 16'd0;
      mat_mem[0] = 12'hF00; mat_mem[1] = 12'h0F0;
      seed = 32'h1234_5678;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(done_o[0] && done_o[1]) && n < budget);
      chk("pass_completes", -1, 128'(done_o[0] && done_o[1]), 128'(1));
   endtask

   task automatic run_pass();
      pulse_start();
      wait_done(800);
   endtask

   initial begin
      int n;
      load_directed();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run_pass();

      ready_mode = 2; stall_n = 0;
      run_pass();
      ready_mode = 0;

      idx_mem[0] = 16'd1; idx_mem[1] = 16'd5; idx_mem[2] = 16'd1;
      idx_mem[3] = 16'd2; idx_mem[4] = 16'd6; idx_mem[5] = 16'd2;
      run_pass();

      // start pulsed while both units sit stalled in Emit, then a restart from Done
      load_directed();
      ready_mode = 3;
      pulse_start();
      n = 0;
      while (!valid_o[1] && n < 50) begin @(negedge clk); n++; end
      chk("reach_emit", 1, 128'(valid_o[1]), 128'(1));
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      ready_mode = 0;
      wait_done(800);
      run_pass();

      // reset in the vertex wait of beat 3, then a cold restart
      pulse_start();
      n = 0;
      while (hs_cnt[1] != 2 && n < 100) begin @(posedge clk); n++; end
      chk("reach_beat3", 1, 128'(hs_cnt[1]), 128'(2));
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      run_pass();

      ready_mode = 1;
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 8; i++) begin
            idx_mem[i] = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) idx_mem[i] = idx_mem[i] | 16'h4000;
         end
         mat_mem[0] = 12'($urandom);
         mat_mem[1] = 12'($urandom);
         seed = $urandom;
         run_pass();
      end
      ready_mode = 0;

      repeat (5) @(posedge clk);
      chk("queue_drained", 0, 128'(pend[0]), 128'(0));
      chk("queue_drained", 1, 128'(pend[1]), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
